// File: rtl/zbt_pkg.sv
// -----------------------------------------------------------------------------
// zbt_pkg
//
// Shared definitions for the labkit ZBT SRAM arbiter slice.
//
//   ZBT_ADDR_W   - SRAM word address width (19 bits on the labkit banks)
//   ZBT_DATA_W   - SRAM data width including the four parity bits (36)
//   ZBT_RD_LAT   - SRAM cycles between a command on the pins and its data
//                  on the bus; also the depth of the tracking pipeline
//   zbt_port_e   - which requester a transaction belongs to
//   zbt_stage_t  - one slot of the tracking pipeline {valid, we, port, wdata}
// -----------------------------------------------------------------------------
package zbt_pkg;

    localparam int ZBT_ADDR_W = 19;
    localparam int ZBT_DATA_W = 36;
    localparam int ZBT_RD_LAT = 2;

    typedef enum logic {
        ZBT_PORT0 = 1'b0,
        ZBT_PORT1 = 1'b1
    } zbt_port_e;

    typedef struct packed {
        logic                  valid;
        logic                  we;
        zbt_port_e             port;
        logic [ZBT_DATA_W-1:0] wdata;
    } zbt_stage_t;

    // Builds a pipeline slot for a freshly granted transaction. Reads carry
    // zero write data so the bus-side data register never shows stale
    // requester data for a read slot.
    function automatic zbt_stage_t zbt_make_stage(
        input logic                  we,
        input zbt_port_e             port,
        input logic [ZBT_DATA_W-1:0] wdata
    );
        zbt_stage_t s;
        s.valid = 1'b1;
        s.we    = we;
        s.port  = port;
        s.wdata = we ? wdata : '0;
        return s;
    endfunction

endpackage

// File: rtl/zbt_rr_arbiter.sv
// -----------------------------------------------------------------------------
// zbt_rr_arbiter
//
// Two-input, one-grant-per-cycle arbiter for the ZBT sequencer.
//
// Ports:
//   clk, reset   - system clock, synchronous active-high reset
//   req0, req1   - requests from the two ports
//   gnt0, gnt1   - combinational grants; at most one is high, both are low
//                  while reset is high
//
// Build option:
//   ZBT_ARB_FIXED_PRIO_EN - when defined port 0 always wins a tie and no
//                           round-robin state exists; port 1 is only served
//                           while req0 is low.
//   Undefined (default)   - round-robin: on a tie the port that was not
//                           granted most recently wins. Reset points the
//                           pointer at port 1 so port 0 wins the first tie.
// -----------------------------------------------------------------------------
module zbt_rr_arbiter
    import zbt_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

`ifdef ZBT_ARB_FIXED_PRIO_EN

    // Strict priority: port 0 first, port 1 only when port 0 is quiet.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            gnt0 = req0;
            gnt1 = req1 & ~req0;
        end
    end

    // clk only feeds the round-robin pointer; keep it visibly consumed.
    logic unused_clk;
    assign unused_clk = clk;

`else

    zbt_port_e last_q;
    zbt_port_e last_d;

    // A single requester always wins; on a tie the pointer decides.
    // The pointer only moves when a grant is actually issued so idle
    // cycles do not disturb the fairness order.
    always_comb begin
        gnt0   = 1'b0;
        gnt1   = 1'b0;
        last_d = last_q;
        if (!reset) begin
            if (req0 && req1) begin
                if (last_q == ZBT_PORT1) begin
                    gnt0 = 1'b1;
                end else begin
                    gnt1 = 1'b1;
                end
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
            if (gnt0) begin
                last_d = ZBT_PORT0;
            end else if (gnt1) begin
                last_d = ZBT_PORT1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= ZBT_PORT1;
        end else begin
            last_q <= last_d;
        end
    end

`endif

endmodule

// File: rtl/zbt_arbiter.sv
// -----------------------------------------------------------------------------
// zbt_arbiter
//
// Two-port arbiter and sequencer for one labkit ZBT SRAM bank. Shares the
// pipelined SRAM between two requesters with single-cycle grants, drives the
// registered ZBT control/address pins and lines write data and read data up
// with the SRAM's two-cycle pipeline. The ram_clk and its feedback path, and
// the bidirectional bus buffer, live in the top-level pin wrapper.
//
// Timing relative to the grant cycle G:
//   G+1  command on ram_ce_b / ram_we_b / ram_address
//   G+3  write data on ram_wdata with ram_wdata_oe high; for a read the SRAM
//        drives ram_rdata and it is captured at the end of this cycle
//   G+4  rvalid<port> pulses with rdata
//
// Ports:
//   clk, reset                 system clock, synchronous active-high reset
//   req*, we*, addr*, wdata*   requester side; wdata sampled in the grant cycle
//   gnt0, gnt1                 combinational grants
//   rvalid0, rvalid1, rdata    registered read return, rdata shared
//   ram_address, ram_we_b,
//   ram_ce_b                   registered SRAM command pins
//   ram_cen_b, ram_adv_ld,
//   ram_oe_b, ram_bwe_b        tied active (full-word, no bursts)
//   ram_wdata, ram_wdata_oe    write data and tristate enable for the wrapper
//   ram_rdata                  data coming back from the bus
//
// Build option:
//   ZBT_ARB_FIXED_PRIO_EN selects fixed port-0 priority inside
//   zbt_rr_arbiter; undefined gives round-robin.
//
// DATA_W and ADDR_W are expected to match ZBT_DATA_W / ZBT_ADDR_W since the
// tracking pipeline slot type comes from the shared package.
// -----------------------------------------------------------------------------
module zbt_arbiter
    import zbt_pkg::*;
#(
    parameter int ADDR_W = ZBT_ADDR_W,
    parameter int DATA_W = ZBT_DATA_W
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,

    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,

    output logic              gnt0,
    output logic              gnt1,

    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,

    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_we_b,
    output logic              ram_ce_b,
    output logic              ram_cen_b,
    output logic              ram_adv_ld,
    output logic              ram_oe_b,
    output logic [3:0]        ram_bwe_b,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_wdata_oe,
    input  logic [DATA_W-1:0] ram_rdata
);

    // -------------------------------------------------------------------------
    // Grant logic
    // -------------------------------------------------------------------------
    zbt_rr_arbiter u_arb (
        .clk   (clk),
        .reset (reset),
        .req0  (req0),
        .req1  (req1),
        .gnt0  (gnt0),
        .gnt1  (gnt1)
    );

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    zbt_stage_t        cmd_q;
    zbt_stage_t        cmd_d;
    zbt_stage_t        pipe_q [ZBT_RD_LAT];
    zbt_stage_t        pipe_d [ZBT_RD_LAT];

    logic [ADDR_W-1:0] ram_address_q;
    logic [ADDR_W-1:0] ram_address_d;
    logic              ram_ce_b_q;
    logic              ram_ce_b_d;
    logic              ram_we_b_q;
    logic              ram_we_b_d;

    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;
    logic              rvalid0_q;
    logic              rvalid0_d;
    logic              rvalid1_q;
    logic              rvalid1_d;

    zbt_stage_t        tail;
    logic              rd_hit;

    // -------------------------------------------------------------------------
    // Command stage: the granted request becomes the pin command for G+1.
    // With no grant the chip is deselected and the address is left where it
    // was so the address pins do not toggle needlessly.
    // -------------------------------------------------------------------------
    always_comb begin
        cmd_d         = '0;
        ram_address_d = ram_address_q;
        if (gnt0) begin
            cmd_d         = zbt_make_stage(we0, ZBT_PORT0, wdata0);
            ram_address_d = addr0;
        end else if (gnt1) begin
            cmd_d         = zbt_make_stage(we1, ZBT_PORT1, wdata1);
            ram_address_d = addr1;
        end
        ram_ce_b_d = ~cmd_d.valid;
        ram_we_b_d = ~(cmd_d.valid & cmd_d.we);
    end

    // -------------------------------------------------------------------------
    // Tracking pipeline: shifts each command along so that the last slot is
    // the transaction whose data phase is on the bus right now (G+3).
    // -------------------------------------------------------------------------
    always_comb begin
        pipe_d[0] = cmd_q;
        for (int i = 1; i < ZBT_RD_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    assign tail = pipe_q[ZBT_RD_LAT-1];

    // -------------------------------------------------------------------------
    // Read return: capture the bus at the end of the read's data phase and
    // flag the owning port for one cycle. rdata is only loaded on a read so
    // it holds its value between returns.
    // -------------------------------------------------------------------------
    always_comb begin
        rd_hit    = tail.valid & ~tail.we;
        rdata_d   = rd_hit ? ram_rdata : rdata_q;
        rvalid0_d = rd_hit & (tail.port == ZBT_PORT0);
        rvalid1_d = rd_hit & (tail.port == ZBT_PORT1);
    end

    // -------------------------------------------------------------------------
    // All registers. Reset drops every in-flight transaction so nothing
    // returns and the bus driver is released on the edge that sees reset.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_q         <= '0;
            for (int i = 0; i < ZBT_RD_LAT; i++) begin
                pipe_q[i] <= '0;
            end
            ram_address_q <= '0;
            ram_ce_b_q    <= 1'b1;
            ram_we_b_q    <= 1'b1;
            rdata_q       <= '0;
            rvalid0_q     <= 1'b0;
            rvalid1_q     <= 1'b0;
        end else begin
            cmd_q         <= cmd_d;
            for (int i = 0; i < ZBT_RD_LAT; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
            ram_address_q <= ram_address_d;
            ram_ce_b_q    <= ram_ce_b_d;
            ram_we_b_q    <= ram_we_b_d;
            rdata_q       <= rdata_d;
            rvalid0_q     <= rvalid0_d;
            rvalid1_q     <= rvalid1_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs. The write data slot is read straight from the last pipeline
    // register, so ram_wdata and its enable are registered too.
    // -------------------------------------------------------------------------
    assign ram_address  = ram_address_q;
    assign ram_ce_b     = ram_ce_b_q;
    assign ram_we_b     = ram_we_b_q;
    assign ram_cen_b    = 1'b0;
    assign ram_adv_ld   = 1'b0;
    assign ram_oe_b     = 1'b0;
    assign ram_bwe_b    = 4'b0000;
    assign ram_wdata    = tail.wdata;
    assign ram_wdata_oe = tail.valid & tail.we;

    assign rdata        = rdata_q;
    assign rvalid0      = rvalid0_q;
    assign rvalid1      = rvalid1_q;

endmodule

// File: tb/tb_zbt_arbiter.sv
// -----------------------------------------------------------------------------
// tb_zbt_arbiter
//
// Directed bench for zbt_arbiter with a small pipelined ZBT SRAM model on the
// pin side (command sampled at an edge, data on the bus two cycles later).
// Honours ZBT_ARB_FIXED_PRIO_EN for the contention expectations.
// -----------------------------------------------------------------------------
module tb_zbt_arbiter;

    localparam int          AW        = 19;
    localparam int          DW        = 36;
    localparam logic [35:0] INIT_BASE = 36'h555500000;
    localparam logic [35:0] BUS_IDLE  = 36'hDEADBEEF0;
    localparam logic [35:0] WDATA_A   = 36'h123456789;
    localparam logic [35:0] WDATA_B   = 36'h0CAFEF00D;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0, we0, req1, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata;
    logic [AW-1:0] ram_address;
    logic          ram_we_b, ram_ce_b, ram_cen_b, ram_adv_ld, ram_oe_b;
    logic [3:0]    ram_bwe_b;
    logic [DW-1:0] ram_wdata;
    logic          ram_wdata_oe;
    logic [DW-1:0] ram_rdata;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    zbt_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .req0         (req0),
        .we0          (we0),
        .addr0        (addr0),
        .wdata0       (wdata0),
        .req1         (req1),
        .we1          (we1),
        .addr1        (addr1),
        .wdata1       (wdata1),
        .gnt0         (gnt0),
        .gnt1         (gnt1),
        .rvalid0      (rvalid0),
        .rvalid1      (rvalid1),
        .rdata        (rdata),
        .ram_address  (ram_address),
        .ram_we_b     (ram_we_b),
        .ram_ce_b     (ram_ce_b),
        .ram_cen_b    (ram_cen_b),
        .ram_adv_ld   (ram_adv_ld),
        .ram_oe_b     (ram_oe_b),
        .ram_bwe_b    (ram_bwe_b),
        .ram_wdata    (ram_wdata),
        .ram_wdata_oe (ram_wdata_oe),
        .ram_rdata    (ram_rdata)
    );

    // SRAM model: 16 words, unwritten words read as INIT_BASE + address.
    logic [35:0] mem [16];
    logic [15:0] mem_wr = '0;
    logic        p1_valid = 1'b0, p1_we = 1'b0, p2_valid = 1'b0, p2_we = 1'b0;
    logic [3:0]  p1_addr = '0, p2_addr = '0;

    always @(posedge clk) begin
        if (p2_valid && p2_we && ram_wdata_oe) begin
            mem[p2_addr]    <= ram_wdata;
            mem_wr[p2_addr] <= 1'b1;
        end
        p1_valid <= ~ram_ce_b;
        p1_we    <= ~ram_we_b;
        p1_addr  <= ram_address[3:0];
        p2_valid <= p1_valid;
        p2_we    <= p1_we;
        p2_addr  <= p1_addr;
    end

    assign ram_rdata = (p2_valid && !p2_we)
                     ? (mem_wr[p2_addr] ? mem[p2_addr] : INIT_BASE + {32'd0, p2_addr})
                     : BUS_IDLE;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic r0, input logic w0, input int a0,
                                 input logic [35:0] d0, input logic r1,
                                 input logic w1, input int a1,
                                 input logic [35:0] d1);
        req0 = r0; we0 = w0; addr0 = a0[AW-1:0]; wdata0 = d0;
        req1 = r1; we1 = w1; addr1 = a1[AW-1:0]; wdata1 = d1;
        #1;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #2;
    endtask

    task automatic applyIdle();
        applyStimulus(1'b0, 1'b0, 0, 36'd0, 1'b0, 1'b0, 0, 36'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int g0cnt, g1cnt, rvcnt;
        reset = 1'b1;
        applyIdle();
        nextCycle();
        nextCycle();

        // ---------------- reset state ----------------
        applyStimulus(1'b1, 1'b1, 5, WDATA_A, 1'b1, 1'b0, 9, 36'd0);
        checkOutput("rst_gnt0", gnt0, 0);
        checkOutput("rst_gnt1", gnt1, 0);
        nextCycle();
        checkOutput("rst_ce_b", ram_ce_b, 1);
        checkOutput("rst_we_b", ram_we_b, 1);
        checkOutput("rst_addr", ram_address, 0);
        checkOutput("rst_oe", ram_wdata_oe, 0);
        checkOutput("rst_wdata", ram_wdata, 0);
        checkOutput("rst_rdata", rdata, 0);
        checkOutput("rst_rvalid", {rvalid1, rvalid0}, 0);
        checkOutput("const_pins", {ram_cen_b, ram_adv_ld, ram_oe_b, ram_bwe_b}, 0);
        applyIdle();
        reset = 1'b0;
        nextCycle();

        // ---------------- port 0 write then read ----------------
        applyStimulus(1'b1, 1'b1, 5, WDATA_A, 1'b0, 1'b0, 0, 36'd0);
        checkOutput("t1_gnt_wr", {gnt1, gnt0}, 2'b01);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 5, 36'd0, 1'b0, 1'b0, 0, 36'd0);
        checkOutput("t1_gnt_rd", {gnt1, gnt0}, 2'b01);
        checkOutput("t1_cmd_wr", {ram_ce_b, ram_we_b}, 2'b00);
        checkOutput("t1_addr_wr", ram_address, 5);
        nextCycle();
        applyIdle();
        checkOutput("t1_cmd_rd", {ram_ce_b, ram_we_b}, 2'b01);
        checkOutput("t1_addr_rd", ram_address, 5);
        checkOutput("t1_oe_g2", ram_wdata_oe, 0);
        nextCycle();
        checkOutput("t1_oe_g3", ram_wdata_oe, 1);
        checkOutput("t1_wdata_g3", ram_wdata, WDATA_A);
        checkOutput("t1_idle_cmd", {ram_ce_b, ram_we_b}, 2'b11);
        nextCycle();
        checkOutput("t1_oe_g4", ram_wdata_oe, 0);
        checkOutput("t1_rv_early", {rvalid1, rvalid0}, 0);
        nextCycle();
        checkOutput("t1_rvalid", {rvalid1, rvalid0}, 2'b01);
        checkOutput("t1_rdata", rdata, WDATA_A);
        nextCycle();
        checkOutput("t1_rv_drop", {rvalid1, rvalid0}, 0);
        checkOutput("t1_rdata_hold", rdata, WDATA_A);

        // ---------------- port 1 read, write, read ----------------
        applyStimulus(1'b0, 1'b0, 0, 36'd0, 1'b1, 1'b0, 1, 36'd0);
        checkOutput("t3_gnt_a", {gnt1, gnt0}, 2'b10);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 0, 36'd0, 1'b1, 1'b1, 2, WDATA_B);
        checkOutput("t3_gnt_b", {gnt1, gnt0}, 2'b10);
        checkOutput("t3_cmd_a", {ram_ce_b, ram_we_b, 19'(ram_address)}, {2'b01, 19'd1});
        nextCycle();
        applyStimulus(1'b0, 1'b0, 0, 36'd0, 1'b1, 1'b0, 3, 36'd0);
        checkOutput("t3_gnt_c", {gnt1, gnt0}, 2'b10);
        checkOutput("t3_cmd_b", {ram_ce_b, ram_we_b, 19'(ram_address)}, {2'b00, 19'd2});
        nextCycle();
        applyIdle();
        checkOutput("t3_cmd_c", {ram_ce_b, ram_we_b, 19'(ram_address)}, {2'b01, 19'd3});
        checkOutput("t3_oe_slot1", ram_wdata_oe, 0);
        nextCycle();
        checkOutput("t3_oe_slot2", ram_wdata_oe, 1);
        checkOutput("t3_wdata", ram_wdata, WDATA_B);
        checkOutput("t3_rv_a", {rvalid1, rvalid0}, 2'b10);
        checkOutput("t3_rdata_a", rdata, INIT_BASE + 36'd1);
        nextCycle();
        checkOutput("t3_oe_slot3", ram_wdata_oe, 0);
        checkOutput("t3_rv_gap", {rvalid1, rvalid0}, 0);
        nextCycle();
        checkOutput("t3_rv_c", {rvalid1, rvalid0}, 2'b10);
        checkOutput("t3_rdata_c", rdata, INIT_BASE + 36'd3);
        nextCycle();
        checkOutput("t3_rv_end", {rvalid1, rvalid0}, 0);

        // ---------------- idle for 10 cycles ----------------
        for (int i = 0; i < 10; i++) begin
            checkOutput($sformatf("idle_cmd_%0d", i), {ram_ce_b, ram_we_b}, 2'b11);
            checkOutput($sformatf("idle_rdata_%0d", i), rdata, INIT_BASE + 36'd3);
            nextCycle();
        end

        // ---------------- contention after a fresh reset ----------------
        reset = 1'b1;
        nextCycle();
        reset = 1'b0;
        g0cnt = 0;
        g1cnt = 0;
        rvcnt = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b0, 8 + i, 36'd0, 1'b1, 1'b0, i, 36'd0);
`ifdef ZBT_ARB_FIXED_PRIO_EN
            checkOutput($sformatf("cont_gnt_%0d", i), {gnt1, gnt0}, 2'b01);
`else
            checkOutput($sformatf("cont_gnt_%0d", i), {gnt1, gnt0},
                        (i % 2 == 0) ? 2'b01 : 2'b10);
`endif
            g0cnt += int'(gnt0);
            g1cnt += int'(gnt1);
            rvcnt += int'(rvalid0) + int'(rvalid1);
            checkOutput($sformatf("cont_rv_excl_%0d", i), rvalid0 & rvalid1, 0);
            nextCycle();
        end
        applyIdle();
        for (int i = 0; i < 6; i++) begin
            rvcnt += int'(rvalid0) + int'(rvalid1);
            checkOutput($sformatf("drain_rv_excl_%0d", i), rvalid0 & rvalid1, 0);
            nextCycle();
        end
`ifdef ZBT_ARB_FIXED_PRIO_EN
        checkOutput("cont_g0_count", g0cnt, 8);
        checkOutput("cont_g1_count", g1cnt, 0);
`else
        checkOutput("cont_g0_count", g0cnt, 4);
        checkOutput("cont_g1_count", g1cnt, 4);
`endif
        checkOutput("cont_rv_count", rvcnt, 8);

        // ---------------- reset two cycles after a read grant ----------------
        applyStimulus(1'b1, 1'b0, 7, 36'd0, 1'b0, 1'b0, 0, 36'd0);
        checkOutput("t5_gnt", {gnt1, gnt0}, 2'b01);
        nextCycle();
        applyIdle();
        nextCycle();
        reset = 1'b1;
        applyIdle();
        nextCycle();
        checkOutput("t5_ce_b", ram_ce_b, 1);
        checkOutput("t5_oe", ram_wdata_oe, 0);
        checkOutput("t5_rv_g3", {rvalid1, rvalid0}, 0);
        applyStimulus(1'b1, 1'b0, 7, 36'd0, 1'b0, 1'b0, 0, 36'd0);
        checkOutput("t5_gnt_in_rst", {gnt1, gnt0}, 0);
        reset = 1'b0;
        applyIdle();
        nextCycle();
        checkOutput("t5_rv_g4", {rvalid1, rvalid0}, 0);
        nextCycle();
        checkOutput("t5_rv_g5", {rvalid1, rvalid0}, 0);
        checkOutput("t5_rdata", rdata, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
